// File: rtl/mm_axi_ssd_mux.sv
// Multiplexed seven-segment display controller behind an AXI4-Lite register file.
// Scans NUM_DIGITS digits with PWM brightness, blink, hex/raw decode and selectable pin polarity.
module mm_axi_ssd_mux #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_DIGITS         = 4,
    parameter int PWM_DIV            = 3125,
    parameter int BLINK_BIT          = 7,
    parameter bit SEG_ACTIVE_LOW     = 1'b0,
    parameter bit SEL_ACTIVE_LOW     = 1'b0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [6:0]                        seg,
    output logic                              dp,
    output logic [NUM_DIGITS-1:0]             digit_sel,
    output logic [3:0]                        led
);

    localparam int unsigned PRE_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [31:0] DIG_MASK  = 32'((1 << NUM_DIGITS) - 1);
    localparam logic [31:0] CTRL_MASK = 32'h0F00_0F03 | (DIG_MASK << 16);

    logic [31:0]      ctrl_q;
    logic [31:0]      data_q;
    logic [7:0]       dp_q;
    logic [PRE_W-1:0] pre_cnt;
    logic [3:0]       phase;
    logic [2:0]       digit_idx;
    logic [7:0]       frame_cnt;

    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [3:0]  nib_c;
    logic [6:0]  seg_c;
    logic [7:0]  sel_c;
    logic [7:0]  blink_c;
    logic        dp_c;
    logic        lit_c;
    logic        unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_fire     = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire     = S_AXI_ARREADY && S_AXI_ARVALID;
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign led         = ctrl_q[27:24];
    assign blink_c     = ctrl_q[23:16];

    // Byte-lane merge of the write data into the addressed register
    always_comb begin
        case (S_AXI_AWADDR[3:2])
            2'd0:    wr_word = ctrl_q;
            2'd1:    wr_word = data_q;
            2'd2:    wr_word = {24'd0, dp_q};
            default: wr_word = 32'd0;
        endcase
        for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) wr_word[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
    end

    always_comb begin
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_word = ctrl_q;
            2'd1:    rd_word = data_q;
            2'd2:    rd_word = {24'd0, dp_q};
            default: rd_word = {16'd0, frame_cnt, 5'd0, digit_idx};
        endcase
    end

    // AXI handshakes and register file
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            ctrl_q        <= '0;
            data_q        <= '0;
            dp_q          <= '0;
        end else begin
            S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
            S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;

            if (wr_fire) begin
                S_AXI_BVALID <= 1'b1;
                case (S_AXI_AWADDR[3:2])
                    2'd0:    ctrl_q <= wr_word & CTRL_MASK;
                    2'd1:    data_q <= wr_word;
                    2'd2:    dp_q   <= wr_word[7:0] & DIG_MASK[7:0];
                    default: ;
                endcase
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (rd_fire) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Free-running scan counters: prescaler -> PWM phase -> digit -> frame
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pre_cnt   <= '0;
            phase     <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
        end else if (pre_cnt == PRE_W'(PWM_DIV - 1)) begin
            pre_cnt <= '0;
            phase   <= phase + 4'd1;
            if (phase == 4'd15) begin
                if (digit_idx == 3'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    digit_idx <= digit_idx + 3'd1;
                end
            end
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_comb begin
        nib_c = data_q[{digit_idx, 2'b00} +: 4];
        seg_c = 7'h00;
        if (ctrl_q[1]) begin
            if (!digit_idx[2]) seg_c = data_q[{digit_idx[1:0], 3'b000} +: 7];
        end else begin
            case (nib_c)
                4'h0: seg_c = 7'h3F;
                4'h1: seg_c = 7'h06;
                4'h2: seg_c = 7'h5B;
                4'h3: seg_c = 7'h4F;
                4'h4: seg_c = 7'h66;
                4'h5: seg_c = 7'h6D;
                4'h6: seg_c = 7'h7D;
                4'h7: seg_c = 7'h07;
                4'h8: seg_c = 7'h7F;
                4'h9: seg_c = 7'h6F;
                4'hA: seg_c = 7'h77;
                4'hB: seg_c = 7'h7C;
                4'hC: seg_c = 7'h39;
                4'hD: seg_c = 7'h5E;
                4'hE: seg_c = 7'h79;
                default: seg_c = 7'h71;
            endcase
        end
        sel_c = 8'd1 << digit_idx;
        dp_c  = dp_q[digit_idx];
        lit_c = ctrl_q[0] && (phase <= ctrl_q[11:8])
                && !(blink_c[digit_idx] && frame_cnt[BLINK_BIT]);
        if (!lit_c) begin
            seg_c = 7'h00;
            sel_c = 8'h00;
            dp_c  = 1'b0;
        end
    end

    // Pin registers; select and segments move on the same edge so no ghosting
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            seg       <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
            digit_sel <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end else begin
            seg       <= seg_c ^ {7{SEG_ACTIVE_LOW}};
            dp        <= dp_c ^ SEG_ACTIVE_LOW;
            digit_sel <= NUM_DIGITS'(sel_c) ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_mm_axi_ssd_mux.sv
// Scoreboard bench for mm_axi_ssd_mux: arithmetic reference model of the scan plus
// register file, AXI responses and display pins checked by an independent monitor.
module tb_mm_axi_ssd_mux;

    localparam int N  = 4;
    localparam int PD = 2;
    localparam int BB = 1;
    localparam logic [31:0] CTRL_MASK = 32'h0F0F_0F03;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [6:0]  seg, seg_n;
    logic        dp, dp_n;
    logic [3:0]  sel, sel_n, led, led_n;
    logic        unused_awready, unused_wready, unused_bvalid, unused_arready, unused_rvalid;
    logic [1:0]  unused_bresp, unused_rresp;
    logic [31:0] unused_rdata;

    mm_axi_ssd_mux #(.NUM_DIGITS(N), .PWM_DIV(PD), .BLINK_BIT(BB)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .seg(seg), .dp(dp), .digit_sel(sel), .led(led));

    mm_axi_ssd_mux #(.NUM_DIGITS(N), .PWM_DIV(PD), .BLINK_BIT(BB),
                     .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_inv (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(unused_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(unused_wready),
        .S_AXI_BRESP(unused_bresp), .S_AXI_BVALID(unused_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(unused_arready),
        .S_AXI_RDATA(unused_rdata), .S_AXI_RRESP(unused_rresp), .S_AXI_RVALID(unused_rvalid), .S_AXI_RREADY(rready),
        .seg(seg_n), .dp(dp_n), .digit_sel(sel_n), .led(led_n));

    int checks = 0;
    int failures = 0;

    logic [31:0] m_ctrl, m_data, m_dp;
    logic [11:0] exp_pins;
    int          cyc;
    logic [31:0] qr[$];
    logic [1:0]  qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake t=%0t", name, $time);
    endtask

    // Expected logical pins {sel, dp, seg} for the counter state t cycles after reset
    function automatic logic [11:0] model_pins(input int t);
        int idx = (t / (16 * PD)) % N;
        int ph  = (t / PD) % 16;
        logic [7:0] fr = 8'((t / (16 * PD * N)) % 256);
        logic [6:0] s;
        logic lit;
        lit = m_ctrl[0] && (ph <= int'(m_ctrl[11:8])) && !(m_ctrl[16 + idx] && fr[BB]);
        if (m_ctrl[1]) s = (idx < 4) ? m_data[8*idx +: 7] : 7'h00;
        else           s = HEX[m_data[4*idx +: 4]];
        if (!lit) return 12'h000;
        return {4'(1 << idx), m_dp[idx], s};
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a, input int t);
        case (a[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_data;
            2'd2:    return m_dp;
            default: return {16'd0, 8'((t / (16 * PD * N)) % 256), 5'd0, 3'((t / (16 * PD)) % N)};
        endcase
    endfunction

    // Reference model: advance one cycle per edge, record accepted transactions
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = '0; m_data = '0; m_dp = '0; cyc = 0; exp_pins = '0;
            qr.delete();
            qb.delete();
        end else begin
            logic [31:0] nv;
            exp_pins = model_pins(cyc);
            if (arready && arvalid) qr.push_back(model_read(araddr, cyc));
            if (awready && awvalid && wvalid) begin
                nv = model_read(awaddr, cyc);
                for (int b = 0; b < 4; b++) if (wstrb[b]) nv[8*b +: 8] = wdata[8*b +: 8];
                case (awaddr[3:2])
                    2'd0: m_ctrl = nv & CTRL_MASK;
                    2'd1: m_data = nv;
                    2'd2: m_dp   = nv & 32'h0000_000F;
                    default: ;
                endcase
                qb.push_back(2'b00);
            end
            cyc++;
        end
    end

    // Monitor: pins every cycle, responses whenever a beat completes
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pins", {20'd0, sel, dp, seg}, {20'd0, exp_pins});
            chk("pins_active_low", {20'd0, sel_n, dp_n, seg_n}, {20'd0, ~exp_pins});
            chk("led", {28'd0, led}, {28'd0, m_ctrl[27:24]});
            if (awready) chk("aw_accept_cond", {29'd0, awvalid, wvalid, bvalid}, 32'b110);
            if (bvalid && bready) begin
                if (qb.size() == 0) fail_now("b_unexpected");
                else chk("bresp", {30'd0, bresp}, {30'd0, qb.pop_front()});
            end
            if (rvalid && rready) begin
                if (qr.size() == 0) fail_now("r_unexpected");
                else chk("rdata", rdata, qr.pop_front());
                chk("rresp", {30'd0, rresp}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!awready && n < 64) begin @(negedge clk); n++; end
        if (!awready) fail_now("aw_timeout");
    endtask

    task automatic wait_b(input int bdly);
        int n = 0;
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("b_held", {31'd0, bvalid}, 32'd1);
            step();
        end
        bready = 1;
        @(negedge clk);
        while (!bvalid && n < 64) begin @(negedge clk); n++; end
        if (!bvalid) fail_now("b_timeout");
        step();
        bready = 0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bdly);
        step();
        awaddr = a; wdata = d; wstrb = s; awvalid = 1;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            chk("aw_waits_for_w", {31'd0, awready}, 32'd0);
            step();
        end
        wvalid = 1;
        wait_aw();
        step();
        awvalid = 0; wvalid = 0;
        wait_b(bdly);
    endtask

    task automatic axi_read(input logic [3:0] a, input int rdly);
        int n = 0;
        step();
        araddr = a; arvalid = 1;
        @(negedge clk);
        while (!arready && n < 64) begin @(negedge clk); n++; end
        if (!arready) fail_now("ar_timeout");
        step();
        arvalid = 0;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("r_held", {31'd0, rvalid}, 32'd1);
            step();
        end
        rready = 1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 64) begin @(negedge clk); n++; end
        if (!rvalid) fail_now("r_timeout");
        step();
        rready = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_axi", {28'd0, awready, bvalid, arready, rvalid}, 32'd0);
        chk("reset_pins_active_low", {20'd0, sel_n, dp_n, seg_n}, 32'h0000_0FFF);

        for (int a = 0; a < 4; a++) axi_read(4'(a * 4), 0);
        axi_write(4'h0, 32'h0A00_0F01, 4'hF, 0, 0);
        axi_read(4'h0, 0);

        // Hex scan over a full frame
        axi_write(4'h4, 32'h0000_A381, 4'hF, 0, 0);
        run(4 * 32 + 10);

        // Raw mode with partial strobes, then decimal points
        axi_write(4'h0, 32'h0000_0F03, 4'hF, 0, 0);
        axi_write(4'h4, 32'h7F00_FF55, 4'b1101, 0, 0);
        axi_read(4'h4, 1);
        run(140);
        axi_write(4'h8, 32'h0000_0005, 4'hF, 0, 0);
        axi_read(4'h8, 0);
        run(140);

        // Brightness 3 and 0
        axi_write(4'h0, 32'h0000_0301, 4'hF, 0, 0);
        run(140);
        axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0);
        run(140);

        // Blink digit 1 across several frame_cnt[1] periods
        axi_write(4'h0, 32'h0002_0F01, 4'hF, 0, 0);
        run(600);
        axi_read(4'hC, 0);

        // AWVALID leading WVALID by 5 cycles
        axi_write(4'h0, 32'h0000_0F01, 4'hF, 5, 0);

        // BREADY held low while a second write waits
        step();
        awaddr = 4'h4; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        wait_aw();
        step();
        awaddr = 4'h8; wdata = 32'h0000_000A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b_held_no_bready", {31'd0, bvalid}, 32'd1);
            chk("no_aw_while_b", {31'd0, awready}, 32'd0);
            step();
        end
        bready = 1;
        step();
        bready = 0;
        wait_aw();
        step();
        awvalid = 0; wvalid = 0;
        wait_b(0);
        axi_read(4'h8, 0);
        axi_read(4'h4, 0);

        // Randomised register traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(4'($urandom_range(0, 3) * 4), $urandom_range(0, 3));
            run($urandom_range(0, 40));
        end

        // Reset while a read response is pending
        step();
        araddr = 4'h4; arvalid = 1; rready = 0;
        @(negedge clk);
        while (!arready) @(negedge clk);
        step();
        arvalid = 0;
        @(negedge clk);
        chk("rvalid_pending", {31'd0, rvalid}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("rvalid_dropped_in_reset", {31'd0, rvalid}, 32'd0);
        chk("pins_in_reset", {20'd0, sel, dp, seg}, 32'd0);
        chk("pins_active_low_in_reset", {20'd0, sel_n, dp_n, seg_n}, 32'h0000_0FFF);
        chk("led_in_reset", {28'd0, led}, 32'd0);
        step();
        rst_n = 1;
        axi_read(4'h0, 0);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
